// File: rtl/pkt_head_slicer_pkg.sv
// Shared constants and state type for the packet head slicer.
// Tag bit positions are shared with the downstream head/meta shift stage.
package pkt_head_slicer_pkg;

   localparam int HEAD_WIDTH_DEF = 512;
   localparam int TAG_WIDTH_DEF  = 4;

   localparam int TAG_START_BIT = 0;
   localparam int TAG_VALID_BIT = 1;
   localparam int TAG_TAIL_BIT  = 2;
   localparam int TAG_SHIFT_BIT = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEAD,
      ST_PAD,
      ST_BODY,
      ST_GAP
   } slicer_state_e;

endpackage

// File: rtl/pkt_head_slicer_if.sv
// Bundles the ingress, head-slice and body streams of the head slicer.
// slave = the slicer's view, master = the producer/consumer view.
interface pkt_head_slicer_if #(
   parameter int HEAD_WIDTH       = 512,
   parameter int TAG_WIDTH        = 4,
   parameter int HEAD_SHIFT_WIDTH = 6
);
   logic                            i_data_valid;
   logic                            o_data_ready;
   logic [HEAD_WIDTH-1:0]           i_data;
   logic                            i_data_last;
   logic [HEAD_SHIFT_WIDTH-1:0]     i_head_shift;
   logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head;
   logic [HEAD_SHIFT_WIDTH-1:0]     o_head_shift;
   logic                            o_body_valid;
   logic                            i_body_ready;
   logic [HEAD_WIDTH-1:0]           o_body;
   logic                            o_body_last;

   modport slave (
      input  i_data_valid, i_data, i_data_last, i_head_shift, i_body_ready,
      output o_data_ready, o_head, o_head_shift, o_body_valid, o_body, o_body_last
   );

   modport master (
      output i_data_valid, i_data, i_data_last, i_head_shift, i_body_ready,
      input  o_data_ready, o_head, o_head_shift, o_body_valid, o_body, o_body_last
   );
endinterface

// File: rtl/pkt_head_slicer_body_out_reg.sv
// One-entry valid/ready output register for the body stream.
// The slot may refill in the same cycle the sink drains it.
module body_out_reg #(
   parameter int WIDTH = 512
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_last,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_last,
   output logic             o_can_accept
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;
   logic             last_d, last_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (i_load) begin
         valid_d = 1'b1;
         data_d  = i_data;
         last_d  = i_last;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign o_valid      = valid_q;
   assign o_data       = data_q;
   assign o_last       = last_q;
   assign o_can_accept = !valid_q || i_ready;

endmodule

// File: rtl/pkt_head_slicer.sv
// Splits each packet into a fixed-length tagged head-slice stream and a backpressured body stream.
// Optional packet/pad statistics outputs are enabled by HEAD_SLICER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for first beat; emits START|VALID slice
// HEAD  | collecting head beats until MAX_HEAD_SLICES slices emitted
// PAD   | short head: emitting zero slices up to MAX_HEAD_SLICES
// BODY  | forwarding remaining beats through the body register
// GAP   | one dead cycle so the shift stage sees a clean start edge
module pkt_head_slicer
   import pkt_head_slicer_pkg::*;
#(
   parameter int HEAD_WIDTH       = HEAD_WIDTH_DEF,
   parameter int TAG_WIDTH        = TAG_WIDTH_DEF,
   parameter int MAX_HEAD_SLICES  = 4,
   parameter int HEAD_SHIFT_WIDTH = 6
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   pkt_head_slicer_if.slave   bus
`ifdef HEAD_SLICER_STATS_EN
   ,
   output logic [31:0]        o_pkt_cnt,
   output logic [31:0]        o_pad_cnt
`endif
);

   localparam int CW = $clog2(MAX_HEAD_SLICES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HEAD_SLICES);

   slicer_state_e                   state_d, state_q;
   logic [CW-1:0]                   cnt_d, cnt_q, cnt_inc;
   logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_d, head_q;
   logic [HEAD_SHIFT_WIDTH-1:0]     shift_d, shift_q;
   logic [TAG_WIDTH-1:0]            tag;
   logic [HEAD_WIDTH-1:0]           slice_data;
   logic                            data_ready;
   logic                            body_load;
   logic                            body_can_accept;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      tag        = '0;
      slice_data = '0;
      data_ready = 1'b0;
      body_load  = 1'b0;
      cnt_inc    = cnt_q + CW'(1);

      case (state_q)
         ST_IDLE: begin
            data_ready = 1'b1;
            if (bus.i_data_valid) begin
               tag[TAG_START_BIT] = 1'b1;
               tag[TAG_VALID_BIT] = 1'b1;
               slice_data         = bus.i_data;
               shift_d            = bus.i_head_shift;
               cnt_d              = CW'(1);
               state_d            = bus.i_data_last ? ST_PAD : ST_HEAD;
            end
         end
         ST_HEAD: begin
            data_ready = 1'b1;
            if (bus.i_data_valid) begin
               tag[TAG_VALID_BIT] = 1'b1;
               slice_data         = bus.i_data;
               cnt_d              = cnt_inc;
               if (cnt_inc == CNT_MAX) begin
                  tag[TAG_TAIL_BIT] = 1'b1;
                  state_d           = bus.i_data_last ? ST_GAP : ST_BODY;
               end else if (bus.i_data_last) begin
                  state_d = ST_PAD;
               end
            end
         end
         ST_PAD: begin
            tag[TAG_VALID_BIT] = 1'b1;
            cnt_d              = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
               tag[TAG_TAIL_BIT] = 1'b1;
               state_d           = ST_GAP;
            end
         end
         ST_BODY: begin
            data_ready = body_can_accept;
            if (bus.i_data_valid && body_can_accept) begin
               body_load = 1'b1;
               if (bus.i_data_last) state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      head_d = {tag, slice_data};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         head_q  <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         shift_q <= shift_d;
      end
   end

   assign bus.o_data_ready = data_ready;
   assign bus.o_head       = head_q;
   assign bus.o_head_shift = shift_q;

   body_out_reg #(
      .WIDTH (HEAD_WIDTH)
   ) u_body_out_reg (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_load       (body_load),
      .i_data       (bus.i_data),
      .i_last       (bus.i_data_last),
      .i_ready      (bus.i_body_ready),
      .o_valid      (bus.o_body_valid),
      .o_data       (bus.o_body),
      .o_last       (bus.o_body_last),
      .o_can_accept (body_can_accept)
   );

`ifdef HEAD_SLICER_STATS_EN
   logic [31:0] pkt_cnt_d, pkt_cnt_q;
   logic [31:0] pad_cnt_d, pad_cnt_q;
   logic        start_evt, pad_evt;

   assign start_evt = (state_q == ST_IDLE) && bus.i_data_valid;
   assign pad_evt   = (state_d == ST_PAD) && (state_q != ST_PAD);

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      pad_cnt_d = pad_cnt_q;
      if (start_evt && (pkt_cnt_q != 32'hFFFF_FFFF)) pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (pad_evt && (pad_cnt_q != 32'hFFFF_FFFF))   pad_cnt_d = pad_cnt_q + 32'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pkt_cnt_q <= '0;
         pad_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         pad_cnt_q <= pad_cnt_d;
      end
   end

   assign o_pkt_cnt = pkt_cnt_q;
   assign o_pad_cnt = pad_cnt_q;
`endif

endmodule
